pipe_result_collector: RTL and testbench
========================================

Name: pipe_result_collector

Overview:
- Far end of a stall-free valid-only pipeline, such as a shift register with valid or an arithmetic pipe. The pipe cannot accept backpressure.
- Meters how many transfers enter the pipe using credits, so every result that emerges always has buffer space.
- Buffers pipe results in an in-order FIFO and re-presents them to a downstream consumer with valid/ready.

Parameters:
- width, 8: data width of pipe results.
- fifo_depth, 4: result buffer entries and total credits. Must be >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low. 0 = reset asserted.
- up_vld  input  1  requester wants to launch a transfer into the pipe.
- up_rdy  output  1  credit available; launch happens on up_vld & up_rdy.
- pipe_vld  input  1  result valid at pipe output.
- pipe_data  input  width  result data at pipe output.
- out_vld  output  1  buffered result available.
- out_rdy  input  1  consumer accepts; pop happens on out_vld & out_rdy.
- out_data  output  width  head-of-FIFO result.
- level  output  $clog2(fifo_depth+1)  FIFO occupancy.
- overflow  output  1  sticky error: pipe_vld arrived while the FIFO was full.

Behaviour:
- Reset (rst=0, async):
  - credits=fifo_depth, FIFO empty, rd_ptr=wr_ptr=0, level=0.
  - out_vld=0, overflow=0.
  - up_rdy forced 0 while rst=0.
- up_rdy = (credits != 0), combinational from registered credits.
- Credit counter, width $clog2(fifo_depth+1):
  - launch only: -1.
  - pop only: +1.
  - launch and pop in the same cycle: unchanged.
  - Never below 0 or above fifo_depth.
- A credit covers a transfer from launch until its result is popped. In-flight plus buffered never exceeds fifo_depth.
- FIFO write:
  - pipe_vld=1 and not full: write pipe_data at wr_ptr.
  - wr_ptr wraps fifo_depth-1 -> 0. Wrap must be correct for non-power-of-two depths.
- FIFO read is show-ahead:
  - out_data = mem[rd_ptr], out_vld = (level != 0).
  - On pop, rd_ptr advances with the same wrap rule.
  - out_data is don't-care when out_vld=0.
- level:
  - +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - A write into a full FIFO with a simultaneous pop is legal and is not an overflow.
- Latency without the optional feature: pipe_vld at edge N gives out_vld=1 after edge N+1, i.e. 1 cycle.
- Ordering: results leave strictly in arrival order. No reorder, no drop except on overflow.
- Overflow:
  - Condition: pipe_vld=1, level=fifo_depth, and no pop that cycle.
  - Data is dropped and FIFO state is unchanged.
  - overflow sets to 1 and stays 1 until reset.
  - Credits are unaffected.
- Reset mid-operation: all buffered data and credits are discarded immediately. Results still in flight in the pipe after reset release are the integrator's problem; the pipe must be reset together with this block.
- out_vld and up_rdy contain no combinational path from out_rdy or up_vld.

Optional Feature:
- Macro: PIPE_RESULT_COLLECTOR_BYPASS_EN.
- Defined:
  - Zero-latency bypass when level=0 and pipe_vld=1: out_vld=1 and out_data=pipe_data combinationally in the same cycle.
  - If out_rdy=1 that cycle, the result is consumed without a FIFO write. level stays 0 and the credit returns.
  - If out_rdy=0, the result is written into the FIFO as normal.
- Not defined: out_vld depends only on registered FIFO state, with 1-cycle latency.

Test Plan:
- Reset:
  - Hold rst=0 with up_vld=1 -> up_rdy=0, out_vld=0, level=0, overflow=0.
  - Release -> up_rdy=1 next cycle; credits=4.
- Credit exhaustion (width=8, fifo_depth=4, 8-stage pipe model, out_rdy=0):
  - Launch 4 transfers on consecutive cycles -> up_rdy=0 after the 4th launch.
  - Results 0x11, 0x22, 0x33, 0x44 arrive 8 cycles later -> level=4, out_data=0x11 held, overflow=0.
- Drain (continuing the previous test, set out_rdy=1):
  - Pops 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles -> level 3, 2, 1, 0, then out_vld=0.
  - up_rdy=1 the cycle after the first pop.
- Simultaneous events:
  - At credits=1, launch and pop in the same cycle -> credits stays 1, up_rdy stays 1.
  - At level=4, pipe_vld and pop in the same cycle -> level stays 4, overflow=0.
- Overflow injection:
  - Force pipe_vld=1 with data 0xEE while level=4 and out_rdy=0 -> overflow=1 sticky, level=4.
  - Subsequent drain yields the original 4 values; 0xEE never appears.
- Mid-operation reset and bypass:
  - Assert rst with level=2 -> out_vld=0, level=0 immediately, without waiting for an edge.
  - With PIPE_RESULT_COLLECTOR_BYPASS_EN, level=0, out_rdy=1, pipe_data=0x5A -> out_vld=1 and out_data=0x5A the same cycle, level stays 0.

Source files
------------

// File: rtl/pipe_result_collector.sv
// Credit-metered result collector for a stall-free valid-only pipe; buffers results in-order for a valid/ready consumer.
// Optional zero-latency bypass when empty: define PIPE_RESULT_COLLECTOR_BYPASS_EN.
module pipe_result_collector #(
    parameter int width      = 8,
    parameter int fifo_depth = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              up_vld,
    output logic                              up_rdy,
    input  logic                              pipe_vld,
    input  logic [width-1:0]                  pipe_data,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [width-1:0]                  out_data,
    output logic [$clog2(fifo_depth+1)-1:0]   level,
    output logic                              overflow
);

    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam int ptr_w = $clog2(fifo_depth);
    localparam logic [cnt_w-1:0] depth_c  = cnt_w'(fifo_depth);
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(fifo_depth - 1);

    logic [cnt_w-1:0] credits;
    logic [width-1:0] mem [fifo_depth];
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w-1:0] wr_ptr;

    logic buf_vld;
    logic full;
    logic launch;
    logic pop;
    logic fifo_pop;
    logic fifo_wr;
    logic drop;
`ifdef PIPE_RESULT_COLLECTOR_BYPASS_EN
    logic bypass;
`endif

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + ptr_one;
    endfunction

    always_comb begin
        buf_vld = (level != '0);
        full    = (level == depth_c);
        up_rdy  = rst & (credits != '0);
        launch  = up_vld & up_rdy;
`ifdef PIPE_RESULT_COLLECTOR_BYPASS_EN
        bypass   = rst & pipe_vld & ~buf_vld;
        out_vld  = buf_vld | bypass;
        out_data = buf_vld ? mem[rd_ptr] : pipe_data;
        pop      = out_vld & out_rdy;
        fifo_pop = buf_vld & out_rdy;
        fifo_wr  = pipe_vld & ~(bypass & out_rdy) & (~full | fifo_pop);
`else
        out_vld  = buf_vld;
        out_data = mem[rd_ptr];
        pop      = out_vld & out_rdy;
        fifo_pop = pop;
        fifo_wr  = pipe_vld & (~full | fifo_pop);
`endif
        // A write into a full FIFO is legal only when the head leaves the same cycle.
        drop = pipe_vld & full & ~fifo_pop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= depth_c;
        end else begin
            case ({launch, pop})
                2'b10:   credits <= credits - cnt_one;
                2'b01:   if (credits != depth_c) credits <= credits + cnt_one;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            case ({fifo_wr, fifo_pop})
                2'b10:   level <= level + cnt_one;
                2'b01:   level <= level - cnt_one;
                default: ;
            endcase
            if (fifo_wr)  wr_ptr <= next_ptr(wr_ptr);
            if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
            if (drop)     overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; level gates out_vld, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= pipe_data;
    end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector with an 8-stage valid-only pipe model in front of it.
// Covers both builds; the bypass case adapts to PIPE_RESULT_COLLECTOR_BYPASS_EN.
module tb_pipe_result_collector;

    localparam int width      = 8;
    localparam int fifo_depth = 4;
    localparam int stages     = 8;
    localparam int lvl_w      = $clog2(fifo_depth + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             up_vld;
    logic             up_rdy;
    logic             pipe_vld;
    logic [width-1:0] pipe_data;
    logic             out_vld;
    logic             out_rdy;
    logic [width-1:0] out_data;
    logic [lvl_w-1:0] level;
    logic             overflow;

    logic [width-1:0] launch_data;
    logic             inj_vld;
    logic [width-1:0] inj_data;
    logic             pv [stages];
    logic [width-1:0] pd [stages];

    int checks = 0;
    int errors = 0;

    logic [width-1:0] first_vec  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [width-1:0] second_vec [4] = '{8'hA3, 8'hA4, 8'hA5, 8'h99};

    always #5 clk = ~clk;

    pipe_result_collector #(.width(width), .fifo_depth(fifo_depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vld    (up_vld),
        .up_rdy    (up_rdy),
        .pipe_vld  (pipe_vld),
        .pipe_data (pipe_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
    );

    // Pipe model: a launch accepted at edge E appears at the pipe output after edge E+7.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < stages; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= up_vld & up_rdy;
            pd[0] <= launch_data;
            for (int i = 1; i < stages; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign pipe_vld  = pv[stages-1] | inj_vld;
    assign pipe_data = inj_vld ? inj_data : pd[stages-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input string tag, input int exp);
        for (int k = 0; k < 40 && 32'(level) != exp; k++) step();
        check(tag, 32'(level), exp);
    endtask

    task automatic launch(input logic [width-1:0] d);
        up_vld      = 1'b1;
        launch_data = d;
        step();
        up_vld      = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        up_vld      = 1'b1;
        out_rdy     = 1'b0;
        launch_data = '0;
        inj_vld     = 1'b0;
        inj_data    = '0;

        // Reset held with a pending request.
        repeat (3) step();
        check("rst_up_rdy",   32'(up_rdy),   0);
        check("rst_out_vld",  32'(out_vld),  0);
        check("rst_level",    32'(level),    0);
        check("rst_overflow", 32'(overflow), 0);
        up_vld = 1'b0;
        rst    = 1'b1;
        step();
        check("rel_up_rdy", 32'(up_rdy), 1);

        // Credit exhaustion: four back-to-back launches with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            up_vld      = 1'b1;
            launch_data = first_vec[i];
            step();
            check($sformatf("exh_up_rdy_%0d", i), 32'(up_rdy), (i < 3) ? 1 : 0);
        end
        up_vld = 1'b0;
        wait_level("exh_level", 4);
        check("exh_out_vld",  32'(out_vld),  1);
        check("exh_head",     32'(out_data), 32'h11);
        check("exh_overflow", 32'(overflow), 0);
        step();
        check("exh_head_held", 32'(out_data), 32'h11);

        // Drain in order.
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data_%0d", i), 32'(out_data), 32'(first_vec[i]));
            step();
            check($sformatf("drain_level_%0d", i), 32'(level), 3 - i);
            if (i == 0) check("drain_up_rdy", 32'(up_rdy), 1);
        end
        check("drain_out_vld", 32'(out_vld), 0);
        out_rdy = 1'b0;

        // Launch and pop together at credits=1.
        launch(8'hA1);
        launch(8'hA2);
        launch(8'hA3);
        wait_level("sim_level3", 3);
        up_vld      = 1'b1;
        launch_data = 8'hA4;
        out_rdy     = 1'b1;
        check("sim_pop_head", 32'(out_data), 32'hA1);
        step();
        up_vld  = 1'b0;
        out_rdy = 1'b0;
        check("sim_credit_hold", 32'(up_rdy), 1);
        check("sim_level2",      32'(level),  2);
        launch(8'hA5);
        check("sim_no_credit", 32'(up_rdy), 0);
        wait_level("sim_level4", 4);

        // Write into a full FIFO with a simultaneous pop.
        inj_vld  = 1'b1;
        inj_data = 8'h99;
        out_rdy  = 1'b1;
        check("full_pop_head", 32'(out_data), 32'hA2);
        step();
        inj_vld = 1'b0;
        out_rdy = 1'b0;
        check("full_pop_level",    32'(level),    4);
        check("full_pop_overflow", 32'(overflow), 0);

        // Overflow injection: data dropped, flag sticky.
        inj_vld  = 1'b1;
        inj_data = 8'hEE;
        step();
        inj_vld = 1'b0;
        check("ovf_flag",  32'(overflow), 1);
        check("ovf_level", 32'(level),    4);
        check("ovf_head",  32'(out_data), 32'hA3);
        repeat (3) step();
        check("ovf_sticky", 32'(overflow), 1);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain_%0d", i), 32'(out_data), 32'(second_vec[i]));
            step();
        end
        out_rdy = 1'b0;
        check("ovf_drain_empty",  32'(out_vld),  0);
        check("ovf_still_sticky", 32'(overflow), 1);
        check("ovf_credit_cap",   32'(up_rdy),   1);

        // Asynchronous reset mid-operation.
        launch(8'hB1);
        launch(8'hB2);
        wait_level("mid_level2", 2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_vld",  32'(out_vld),  0);
        check("mid_rst_level",    32'(level),    0);
        check("mid_rst_up_rdy",   32'(up_rdy),   0);
        check("mid_rst_overflow", 32'(overflow), 0);
        #1 rst = 1'b1;
        step();
        check("mid_rel_up_rdy", 32'(up_rdy), 1);

        // Result arriving at an empty FIFO with the consumer ready.
        inj_vld  = 1'b1;
        inj_data = 8'h5A;
        out_rdy  = 1'b1;
        #1;
`ifdef PIPE_RESULT_COLLECTOR_BYPASS_EN
        check("byp_out_vld",  32'(out_vld),  1);
        check("byp_out_data", 32'(out_data), 32'h5A);
        step();
        inj_vld = 1'b0;
        check("byp_level",   32'(level),   0);
        check("byp_out_vld_after", 32'(out_vld), 0);
`else
        check("lat_out_vld0", 32'(out_vld), 0);
        step();
        inj_vld = 1'b0;
        check("lat_out_vld1",  32'(out_vld),  1);
        check("lat_out_data",  32'(out_data), 32'h5A);
        check("lat_level1",    32'(level),    1);
        step();
        check("lat_level0",    32'(level),    0);
`endif
        out_rdy = 1'b0;
        check("end_up_rdy", 32'(up_rdy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
